// File: rtl/display_pkg.sv
// display_pkg -- shared constants for the display scan controller:
// window-state encodings, scan-index constants and seven-segment patterns.
package display_pkg;

   // One-hot so the state register can drive the win output directly
   typedef enum logic [2:0] {
      W0 = 3'b001,   // digits 2..0
      W1 = 3'b010,   // digits 3..1
      W2 = 3'b100    // digits 4..2
   } win_state_t;

   localparam logic [1:0] SCAN_LOW  = 2'd0;
   localparam logic [1:0] SCAN_MID  = 2'd1;
   localparam logic [1:0] SCAN_HIGH = 2'd2;
   localparam logic [1:0] SCAN_SIGN = 2'd3;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   // BCD digit to segment pattern; non-decimal codes blank the digit
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse -- two-flop synchronizer, optional debounce and rising-edge
// detector for one raw push button. Define DISPLAY_SCAN_DEBOUNCE_EN to
// require DEBOUNCE_CYCLES consecutive equal samples before a level change
// is accepted. A button already held when reset releases is ignored until
// it has been seen low.
module btn_pulse #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q, prev_d;
   logic       armed_q, armed_d;
   logic [1:0] fill_q, fill_d;
   logic       accepted;

`ifdef DISPLAY_SCAN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // Next-state for synchronizer, arming, debounce and edge detection
   always_comb begin
      sync1_d  = btn;
      sync2_d  = sync1_q;
      fill_d   = {fill_q[0], 1'b1};
      // Arm only once a genuine low has passed through the synchronizer
      armed_d  = armed_q | (fill_q[1] & ~sync2_q);
`ifdef DISPLAY_SCAN_DEBOUNCE_EN
      level_d  = level_q;
      cnt_d    = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      accepted = level_q;
`else
      accepted = sync2_q;
`endif
      prev_d   = accepted;
      pulse    = armed_q & accepted & ~prev_q;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         fill_q  <= 2'b00;
`ifdef DISPLAY_SCAN_DEBOUNCE_EN
         level_q <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         armed_q <= armed_d;
         fill_q  <= fill_d;
`ifdef DISPLAY_SCAN_DEBOUNCE_EN
         level_q <= level_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller -- multiplexes a 3-digit window of a 5-digit BCD
// value plus a sign position onto a 4-digit seven-segment display. BTNL and
// BTNR scroll the window. Define DISPLAY_SCAN_DEBOUNCE_EN to debounce the
// buttons (see btn_pulse).
module display_scan_controller
   import display_pkg::*;
#(
   parameter int REFRESH_DIV     = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [19:0] bcd,
   input  logic        sign,
   input  logic        BTNL,
   input  logic        BTNR,
   output logic [3:0]  anode_n,
   output logic [6:0]  seg_n,
   output logic [2:0]  win
);

   localparam int RW = $clog2(REFRESH_DIV);

   logic          step_l, step_r;
   win_state_t    state_q, state_d;
   logic [RW-1:0] ref_q, ref_d;
   logic [1:0]    scan_q, scan_d;
   logic [3:0]    anode_q, anode_d;
   logic [6:0]    seg_q, seg_d;
   logic [2:0]    win_base;
   logic [2:0]    digit_idx;
   logic [3:0]    nibble;

   btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (BTNL),
      .pulse (step_l)
   );

   btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (BTNR),
      .pulse (step_r)
   );

   // Window FSM: saturating scroll, simultaneous steps cancel
   always_comb begin
      state_d = state_q;
      win     = state_q;
      if (step_l && !step_r) begin
         case (state_q)
            W0:      state_d = W1;
            W1:      state_d = W2;
            default: state_d = W2;
         endcase
      end else if (step_r && !step_l) begin
         case (state_q)
            W2:      state_d = W1;
            W1:      state_d = W0;
            default: state_d = W0;
         endcase
      end
   end

   // Refresh divider and scan index; independent of the window
   always_comb begin
      ref_d  = ref_q + 1'b1;
      scan_d = scan_q;
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
         ref_d  = '0;
         scan_d = scan_q + 2'd1;
      end
   end

   // Select the digit for the current slot and form the next output pattern
   always_comb begin
      case (state_q)
         W0:      win_base = 3'd0;
         W1:      win_base = 3'd1;
         default: win_base = 3'd2;
      endcase
      digit_idx = win_base + {1'b0, scan_q};
      case (digit_idx)
         3'd0:    nibble = bcd[3:0];
         3'd1:    nibble = bcd[7:4];
         3'd2:    nibble = bcd[11:8];
         3'd3:    nibble = bcd[15:12];
         3'd4:    nibble = bcd[19:16];
         default: nibble = 4'hF;
      endcase
      anode_d = ~(4'b0001 << scan_q);
      if (scan_q == SCAN_SIGN) begin
         seg_d = sign ? SEG_MINUS : SEG_BLANK;
      end else begin
         seg_d = seg_decode(nibble);
      end
   end

   // State and registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= W0;
         ref_q   <= '0;
         scan_q  <= SCAN_LOW;
         anode_q <= 4'b1111;
         seg_q   <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         scan_q  <= scan_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
      end
   end

   assign anode_n = anode_q;
   assign seg_n   = seg_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller -- directed self-checking bench for
// display_scan_controller with REFRESH_DIV=4, DEBOUNCE_CYCLES=8.
module tb_display_scan_controller;

   localparam int RDIV = 4;
   localparam int DCYC = 8;
`ifdef DISPLAY_SCAN_DEBOUNCE_EN
   localparam int LAT  = DCYC + 3;
`else
   localparam int LAT  = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] bcd;
   logic        sign;
   logic        BTNL;
   logic        BTNR;
   logic [3:0]  anode_n;
   logic [6:0]  seg_n;
   logic [2:0]  win;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [2:0]  exp_win;
   logic [6:0]  seg_tab [0:15];

   display_scan_controller #(
      .REFRESH_DIV     (RDIV),
      .DEBOUNCE_CYCLES (DCYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bcd     (bcd),
      .sign    (sign),
      .BTNL    (BTNL),
      .BTNR    (BTNR),
      .anode_n (anode_n),
      .seg_n   (seg_n),
      .win     (win)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) cyc++;
   endtask

   // Expected anode/segments for the edge count since reset release
   task automatic check_disp(input string tag);
      int         slot;
      int         base;
      int         digit;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic [3:0] nib;
      slot   = ((cyc - 1) / RDIV) % 4;
      base   = (exp_win == 3'b001) ? 0 : (exp_win == 3'b010) ? 1 : 2;
      digit  = base + slot;
      exp_an = 4'b1111;
      exp_an[slot] = 1'b0;
      if (slot == 3) begin
         exp_seg = sign ? 7'b0111111 : 7'h7F;
      end else begin
         nib     = bcd[digit*4 +: 4];
         exp_seg = seg_tab[nib];
      end
      check_val({tag, " anode"}, anode_n, exp_an);
      check_val({tag, " seg"}, seg_n, exp_seg);
   endtask

   // Raise the selected buttons, check the window just before and at the step edge
   task automatic press(input bit left, input bit right, input logic [2:0] next, input string tag);
      BTNL = left;
      BTNR = right;
      for (int i = 0; i < LAT - 1; i++) tick();
      check_val({tag, " before"}, win, exp_win);
      tick();
      exp_win = next;
      check_val({tag, " step"}, win, exp_win);
      BTNL = 1'b0;
      BTNR = 1'b0;
      repeat (20) tick();
   endtask

   initial begin
      seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
      seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
      seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;

      rst_n   = 1'b0;
      bcd     = 20'h12345;
      sign    = 1'b1;
      BTNL    = 1'b0;
      BTNR    = 1'b0;
      exp_win = 3'b001;
      repeat (3) tick();
      check_val("reset anode", anode_n, 4'b1111);
      check_val("reset seg", seg_n, 7'h7F);
      check_val("reset win", win, 3'b001);

      // Plain scan in W0: 5,4,3,'-'
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check_disp($sformatf("scan W0 c%0d", cyc));
      end
      check_val("win W0", win, 3'b001);

      // Scroll left to saturation, show W2, scroll back
      press(1'b1, 1'b0, 3'b010, "L1");
      press(1'b1, 1'b0, 3'b100, "L2");
      press(1'b1, 1'b0, 3'b100, "L3 sat");
      for (int i = 0; i < 16; i++) begin
         tick();
         check_disp($sformatf("scan W2 c%0d", cyc));
      end
      press(1'b0, 1'b1, 3'b010, "R1");
      press(1'b0, 1'b1, 3'b001, "R2");
      press(1'b0, 1'b1, 3'b001, "R3 sat");

      // Held button: exactly one step
      BTNL = 1'b1;
      for (int i = 0; i < LAT - 1; i++) tick();
      check_val("hold before", win, exp_win);
      tick();
      exp_win = 3'b010;
      check_val("hold step", win, exp_win);
      repeat (100 - LAT) tick();
      check_val("hold 100", win, exp_win);
      BTNL = 1'b0;
      repeat (20) tick();

      // Both buttons in the same cycle from W1
      press(1'b1, 1'b1, 3'b010, "LR same");

`ifdef DISPLAY_SCAN_DEBOUNCE_EN
      // Short glitches are ignored, a long press steps after DCYC+3 edges
      for (int g = 0; g < 2; g++) begin
         BTNL = 1'b1;
         repeat (5) tick();
         BTNL = 1'b0;
         repeat (15) tick();
         check_val($sformatf("glitch %0d", g), win, exp_win);
      end
      BTNL = 1'b1;
      repeat (DCYC + 2) tick();
      check_val("deb before", win, exp_win);
      tick();
      exp_win = 3'b100;
      check_val("deb step", win, exp_win);
      repeat (20 - LAT) tick();
      BTNL = 1'b0;
      repeat (20) tick();
`else
      press(1'b1, 1'b0, 3'b100, "L to W2");
`endif

      // Asynchronous reset mid-scan in W2, with BTNL held through release
      repeat (6) tick();
      rst_n = 1'b0;
      BTNL  = 1'b1;
      bcd   = 20'h12A45;
      sign  = 1'b0;
      #1;
      check_val("async rst anode", anode_n, 4'b1111);
      check_val("async rst seg", seg_n, 7'h7F);
      check_val("async rst win", win, 3'b001);
      exp_win = 3'b001;
      cyc     = 0;
      repeat (2) tick();
      check_val("in rst anode", anode_n, 4'b1111);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check_disp($sformatf("scan A c%0d", cyc));
         if (i == 8) check_val("blank digit A", seg_n, 7'h7F);
      end
      check_val("held at release", win, 3'b001);
      BTNL = 1'b0;
      repeat (20) tick();
      press(1'b1, 1'b0, 3'b010, "after rearm");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
